// File: rtl/phase_freq_detector_tdc.sv
// Phase/frequency detector with a counter-based TDC: signed phase error in clk cycles plus lock detect.
// Optional macro PFD_TIMEOUT_EN: close an open measurement when the counter saturates.
module phase_freq_detector_tdc #(
    parameter int CNT_W       = 8,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_COUNT  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    ref_in,
    input  logic                    fb_in,
    output logic                    up,
    output logic                    dn,
    output logic signed [CNT_W-1:0] err,
    output logic                    err_valid,
    output logic                    lock
);
    localparam int CW = CNT_W - 1;
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0]           MAX    = '1;
    localparam logic signed [CNT_W-1:0] EMAX   = CNT_W'(2**CW - 1);
    localparam logic [CNT_W-1:0]        THRESH = CNT_W'(LOCK_THRESH);
    localparam logic [LW-1:0]           LCNT   = LW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} state_t;

    state_t                  r_state, w_state_nx;
    logic [CW-1:0]           r_cnt, w_cnt_nx, w_cnt_inc;
    logic signed [CNT_W-1:0] r_err, w_err_nx, w_pos;
    logic                    r_err_valid, w_err_valid_nx;
    logic [LW-1:0]           r_lock_cnt;
    logic [2:0]              r_ref_sync, r_fb_sync, r_settle;
    logic                    w_ref_rise, w_fb_rise;
    logic [CNT_W-1:0]        w_abs_err;

    // [1:0] synchronizer, [2] delay flop; r_settle blocks rises until the delay flop holds a real sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref_sync <= '0;
            r_fb_sync  <= '0;
            r_settle   <= '0;
        end else begin
            r_ref_sync <= {r_ref_sync[1:0], ref_in};
            r_fb_sync  <= {r_fb_sync[1:0], fb_in};
            r_settle   <= {r_settle[1:0], 1'b1};
        end
    end

    assign w_ref_rise = r_settle[2] & r_ref_sync[1] & ~r_ref_sync[2];
    assign w_fb_rise  = r_settle[2] & r_fb_sync[1] & ~r_fb_sync[2];
    assign w_pos      = {1'b0, r_cnt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_err       <= '0;
            r_err_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_err       <= w_err_nx;
            r_err_valid <= w_err_valid_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_err_nx       = r_err;
        w_err_valid_nx = 1'b0;
        w_cnt_inc      = (r_cnt == MAX) ? MAX : r_cnt + 1'b1;
        case (r_state)
            IDLE: begin
                if (w_ref_rise && w_fb_rise) begin
                    w_err_nx       = '0;
                    w_err_valid_nx = 1'b1;
                end else if (w_ref_rise) begin
                    w_state_nx = REF_LEAD;
                    w_cnt_nx   = CW'(1);
                end else if (w_fb_rise) begin
                    w_state_nx = FB_LEAD;
                    w_cnt_nx   = CW'(1);
                end
            end
            REF_LEAD: begin
                if (w_fb_rise) begin
                    w_err_nx       = w_pos;
                    w_err_valid_nx = 1'b1;
                    if (w_ref_rise) begin
                        w_cnt_nx = CW'(1);
                    end else begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end
                end else if (w_ref_rise) begin
                    w_err_nx       = EMAX;
                    w_err_valid_nx = 1'b1;
                    w_cnt_nx       = CW'(1);
`ifdef PFD_TIMEOUT_EN
                end else if (r_cnt == MAX) begin
                    w_err_nx       = EMAX;
                    w_err_valid_nx = 1'b1;
                    w_state_nx     = IDLE;
                    w_cnt_nx       = '0;
`endif
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            FB_LEAD: begin
                if (w_ref_rise) begin
                    w_err_nx       = -w_pos;
                    w_err_valid_nx = 1'b1;
                    if (w_fb_rise) begin
                        w_cnt_nx = CW'(1);
                    end else begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end
                end else if (w_fb_rise) begin
                    w_err_nx       = -EMAX;
                    w_err_valid_nx = 1'b1;
                    w_cnt_nx       = CW'(1);
`ifdef PFD_TIMEOUT_EN
                end else if (r_cnt == MAX) begin
                    w_err_nx       = -EMAX;
                    w_err_valid_nx = 1'b1;
                    w_state_nx     = IDLE;
                    w_cnt_nx       = '0;
`endif
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
        if (!enable) begin
            w_state_nx     = IDLE;
            w_cnt_nx       = '0;
            w_err_nx       = r_err;
            w_err_valid_nx = 1'b0;
        end
    end

    // err never reaches -2^(CNT_W-1), so the negation below cannot overflow
    assign w_abs_err = r_err[CNT_W-1] ? $unsigned(-r_err) : $unsigned(r_err);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_cnt <= '0;
        end else if (!enable) begin
            r_lock_cnt <= '0;
        end else if (r_err_valid) begin
            if (w_abs_err > THRESH)
                r_lock_cnt <= '0;
            else if (r_lock_cnt != LCNT)
                r_lock_cnt <= r_lock_cnt + 1'b1;
        end
    end

    assign up        = (r_state == REF_LEAD);
    assign dn        = (r_state == FB_LEAD);
    assign err       = r_err;
    assign err_valid = r_err_valid;
    assign lock      = (r_lock_cnt == LCNT);
endmodule

// File: tb/tb_phase_freq_detector_tdc.sv
// Randomized + directed bench for phase_freq_detector_tdc against a timestamp-based reference model.
module tb_phase_freq_detector_tdc;
    localparam int CNT_W = 8, MAXV = 127, THR = 2, LC = 8;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b1, ref_in = 1'b0, fb_in = 1'b0;
    logic up, dn, err_valid, lock;
    logic signed [CNT_W-1:0] err;

    int tests = 0, fails = 0;

    phase_freq_detector_tdc #(.CNT_W(CNT_W), .LOCK_THRESH(THR), .LOCK_COUNT(LC)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ref_in(ref_in), .fb_in(fb_in),
        .up(up), .dn(dn), .err(err), .err_valid(err_valid), .lock(lock)
    );

    always #5 clk = ~clk;

    // Model: input level history per edge, open measurement as (direction, start edge)
    int  n_edge = 0, mode = 0, ts = 0, m_err = 0, streak = 0;
    bit  m_ev = 1'b0;
    bit  rh[0:3], fh[0:3];
    int  ev_cnt = 0, up_cyc = 0, dn_cyc = 0;
    int  errq[$];
    int  b_ev, b_up, b_dn, b_q, en_hold = 0, d;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int q_at(input int i);
        if (i >= 0 && i < errq.size()) return errq[i];
        return -9999;
    endfunction

    task automatic model_step();
        int c;
        bit rr, fr, nev, closing, slip;
        if (reset) begin
            n_edge = 0; mode = 0; ts = 0; m_err = 0; m_ev = 1'b0; streak = 0;
            for (int i = 0; i < 4; i++) begin rh[i] = 1'b0; fh[i] = 1'b0; end
            return;
        end
        n_edge++;
        for (int i = 3; i > 0; i--) begin rh[i] = rh[i-1]; fh[i] = fh[i-1]; end
        rh[0] = ref_in; fh[0] = fb_in;
        rr = (n_edge >= 4) && rh[2] && !rh[3];
        fr = (n_edge >= 4) && fh[2] && !fh[3];
        if (!enable) streak = 0;
        else if (m_ev) streak = (((m_err < 0) ? -m_err : m_err) <= THR) ? ((streak < LC) ? streak + 1 : LC) : 0;
        nev = 1'b0;
        c = (n_edge - ts > MAXV) ? MAXV : n_edge - ts;
        if (!enable) begin
            mode = 0;
        end else if (mode == 0) begin
            if (rr && fr) begin nev = 1'b1; m_err = 0; end
            else if (rr) begin mode = 1; ts = n_edge; end
            else if (fr) begin mode = -1; ts = n_edge; end
        end else begin
            closing = (mode == 1) ? fr : rr;
            slip    = (mode == 1) ? rr : fr;
            if (closing) begin
                nev = 1'b1; m_err = mode * c;
                if (slip) ts = n_edge; else mode = 0;
            end else if (slip) begin
                nev = 1'b1; m_err = mode * MAXV; ts = n_edge;
            end
`ifdef PFD_TIMEOUT_EN
            else if (c == MAXV) begin
                nev = 1'b1; m_err = mode * MAXV; mode = 0;
            end
`endif
        end
        m_ev = nev;
    endtask

    // One clk per iteration: update model at the edge, compare 1 time unit later, return at negedge
    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            model_step();
            #1;
            tests++;
            if (up !== (mode == 1) || dn !== (mode == -1) || err_valid !== m_ev ||
                lock !== (streak == LC) || err !== CNT_W'(m_err)) begin
                fails++;
                $display("FAIL cycle@%0t: got up=%b dn=%b ev=%b lock=%b err=%0d, expected up=%b dn=%b ev=%b lock=%b err=%0d",
                         $time, up, dn, err_valid, lock, err, mode == 1, mode == -1, m_ev, streak == LC, m_err);
            end
            if (err_valid === 1'b1) begin ev_cnt++; errq.push_back(int'(err)); end
            if (up === 1'b1) up_cyc++;
            if (dn === 1'b1) dn_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic snap();
        b_ev = ev_cnt; b_up = up_cyc; b_dn = dn_cyc; b_q = errq.size();
    endtask

    task automatic lead_meas(input bit ref_first, input int dly);
        if (ref_first) ref_in = 1'b1; else fb_in = 1'b1;
        tick(dly);
        ref_in = 1'b1; fb_in = 1'b1;
        tick(5);
        ref_in = 1'b0; fb_in = 1'b0;
        tick(4);
    endtask

    initial begin
        tick(3);
        chk("reset_outs", {up, dn, err_valid, lock, err}, 0);
        reset = 1'b0;
        tick(6);

        snap(); lead_meas(1'b1, 5);
        chk("ref_lead5_ev", ev_cnt - b_ev, 1);
        chk("ref_lead5_err", q_at(b_q), 5);
        chk("ref_lead5_up", up_cyc - b_up, 5);
        chk("ref_lead5_dn", dn_cyc - b_dn, 0);

        snap(); lead_meas(1'b0, 3);
        chk("fb_lead3_err", q_at(b_q), -3);
        chk("fb_lead3_dn", dn_cyc - b_dn, 3);
        chk("fb_lead3_up", up_cyc - b_up, 0);

        snap(); lead_meas(1'b1, 0);
        chk("simul_ev", ev_cnt - b_ev, 1);
        chk("simul_err", q_at(b_q), 0);
        chk("simul_updn", (up_cyc - b_up) + (dn_cyc - b_dn), 0);

        snap();
        ref_in = 1'b1; tick(3); ref_in = 1'b0; tick(37);
        ref_in = 1'b1; tick(4); fb_in = 1'b1; tick(6);
        ref_in = 1'b0; fb_in = 1'b0; tick(4);
        chk("slip_ev", ev_cnt - b_ev, 2);
        chk("slip_err", q_at(b_q), 127);
        chk("slip_restart_err", q_at(b_q + 1), 4);
        chk("slip_up", up_cyc - b_up, 44);

        for (int i = 0; i < 8; i++) begin
            lead_meas(i[0] == 1'b0, i % 3);
            if (i == 6) chk("lock_after7", lock, 0);
        end
        chk("lock_after8", lock, 1);
        ref_in = 1'b1; tick(10); fb_in = 1'b1; tick(3);
        chk("big_err_ev", err_valid, 1);
        chk("big_err_val", err, 10);
        chk("big_err_lock_held", lock, 1);
        tick(1);
        chk("big_err_unlock", lock, 0);
        ref_in = 1'b0; fb_in = 1'b0; tick(4);

        snap();
        ref_in = 1'b1; tick(3);
        chk("en_open_up", up, 1);
        enable = 1'b0; tick(1);
        chk("en_off_up", up, 0);
        chk("en_off_err_hold", err, 10);
        fb_in = 1'b1; tick(5); enable = 1'b1; tick(5);
        chk("en_off_no_ev", ev_cnt - b_ev, 0);
        ref_in = 1'b0; fb_in = 1'b0; tick(4);

        snap();
        ref_in = 1'b1; tick(3);
        chk("rst_open_up", up, 1);
        reset = 1'b1; #1;
        chk("rst_async_outs", {up, dn, err_valid, lock, err}, 0);
        tick(2); reset = 1'b0; tick(8);
        chk("rst_no_ev", ev_cnt - b_ev, 0);
        chk("rst_high_in_no_rise", up, 0);
        ref_in = 1'b0; tick(4);

        snap();
        ref_in = 1'b1; tick(3); ref_in = 1'b0; tick(130);
`ifdef PFD_TIMEOUT_EN
        chk("timeout_ev", ev_cnt - b_ev, 1);
        chk("timeout_err", q_at(b_q), 127);
        chk("timeout_idle", up, 0);
`else
        chk("sat_no_ev", ev_cnt - b_ev, 0);
        chk("sat_open", up, 1);
        fb_in = 1'b1; tick(4);
        chk("sat_err", q_at(b_q), 127);
        chk("sat_closed", up, 0);
        fb_in = 1'b0; tick(4);
`endif

        // loop-like tracking: small random offsets with occasional large ones
        for (int i = 0; i < 60; i++) begin
            d = (i % 13 == 12) ? 5 : $urandom_range(0, 2);
            lead_meas($urandom_range(0, 1) == 1, d);
        end

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) ref_in = ~ref_in;
            if ($urandom_range(0, 5) == 0) fb_in = ~fb_in;
            if (en_hold > 0) begin
                en_hold--;
                if (en_hold == 0) enable = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                enable = 1'b0;
                en_hold = $urandom_range(1, 5);
            end
            if ($urandom_range(0, 1499) == 0) begin
                reset = 1'b1; tick(2); reset = 1'b0;
            end
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
